regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back side of the MIPS register file: collects destination-register writes from the ALU and load paths, buffers them in a small FIFO, and drives the register file's `WB`/`writeReg`/`writeData` write port at most once per cycle. The register file has registered reads and a same-edge write, so this block also provides forwarding. Read-register numbers are compared against every pending write, and a hit returns the newest pending data. It sits between the MEM/WB pipeline register and the register file.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `aluValid`  in  1  ALU result write request
- `aluReg`  in  5  ALU destination register
- `aluData`  in  32  ALU result
- `aluReady`  out  1  ALU request accepted this cycle
- `memValid`  in  1  load result write request
- `memReg`  in  5  load destination register
- `memData`  in  32  load data
- `memReady`  out  1  load request accepted this cycle
- `wbStall`  in  1  register-file write port unavailable; hold FIFO head
- `WB`  out  1  register-file write enable (registered)
- `writeReg`  out  5  register-file write address (registered)
- `writeData`  out  32  register-file write data (registered)
- `readReg1`, `readReg2`  in  5 each  register-file read addresses, for forwarding lookup
- `fwdHit1`, `fwdHit2`  out  1 each  pending write exists for `readRegN` (combinational)
- `fwdData1`, `fwdData2`  out  32 each  newest pending data for `readRegN` (combinational)
- `count`  out  log2(DEPTH)+1  FIFO occupancy
- `full`, `empty`  out  1 each  FIFO status

## Operation
- Arbitration: memory has priority over the ALU.
  - `memReady = !full`.
  - `aluReady = !full && !memValid`.
  - At most one request is accepted per cycle; the accepted request is the one with valid && ready.
- Accepted request with reg 0: acknowledged and discarded. Not enqueued, `count` unchanged.
- Accepted request with reg ≠ 0: written at the FIFO tail; tail pointer wraps modulo DEPTH.
- Drain: on each posedge with `!wbStall && !empty`, the head is popped into the output register, with `WB<=1`, `writeReg<=head.reg` and `writeData<=head.data`.
  - Otherwise `WB<=0`; `writeReg` and `writeData` hold their values.
- Simultaneous enqueue and pop is allowed (`count` unchanged). Enqueue is never allowed while full, even if a pop occurs in the same cycle.
- Forwarding search set: the output stage (when `WB=1`) plus all valid FIFO entries.
  - `readRegN=0` never hits.
  - On a match, priority is newest FIFO entry first, then older entries, then the output stage.
  - On a miss, `fwdHitN=0` and `fwdDataN=0`.
- Writes to the same register retire in acceptance order; no coalescing.
- `full = (count==DEPTH)`, `empty = (count==0)`.

## Timing
- Reset (posedge with `rst=1`):
  - Outputs: `WB=0`, `writeReg=0`, `writeData=0`, `count=0`, `empty=1`, `full=0`, `fwdHit1/2=0`, `fwdData1/2=0`.
  - State: both pointers are cleared.
  - `rst` overrides all requests in that cycle. Pending entries and the output stage are discarded with no write.
- Latency, empty FIFO and no stall:
  - request accepted at edge N;
  - `WB=1` after edge N+1;
  - register file updates at edge N+2.
- `aluReady`, `memReady`, `full`, `empty` and `count` reflect state before the current edge. Ready does not depend on the same-cycle pop.
- `wbStall=1` for k cycles holds the head for k cycles with `WB=0`. Requests keep enqueuing until full.
- Forwarding outputs are combinational from current state, valid in the same cycle as `readRegN`.

## Test plan
- Single write: `aluValid=1`, `aluReg=20`, `aluData=50` for one cycle.
  - Next cycle: `count=1`, `fwdHit` for `readReg2=20` is 1 with data 50.
  - One cycle later: `WB=1`, `writeReg=20`, `writeData=50`.
  - Then `count=0` and `WB=0`.
- Simultaneous requests: `memValid` (r3=7) and `aluValid` (r4=9) both asserted.
  - Cycle 1: `memReady=1`, `aluReady=0`.
  - ALU accepted the next cycle.
  - Retire order on the write port is r3=7, then r4=9.
- Full and wrap: `wbStall=1`, 5 ALU requests r1..r5 = 11..15.
  - First 4 accepted; `full=1`, `aluReady=0`.
  - Release stall while enqueuing r5: retire sequence r1..r5 in order, with r5 stored in wrapped slot 0.
- Reg 0 drop: request r0=99 is acknowledged with `count` unchanged and no `WB` pulse. `fwdHit` for `readReg1=0` stays 0.
- Newest-wins: `wbStall=1`, writes r5=1 then r5=2.
  - `fwdData1` is 2 for `readReg1=5`.
  - After drain, while r5=2 sits in the output stage with `WB=1`, `fwdData1=2`.
- Reset mid-operation: 3 entries pending with `wbStall=1`; assert `rst` for one cycle.
  - Result: `count=0`, `WB=0`, all `fwdHit=0`.
  - After `wbStall` is released, no writes occur.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: buffers ALU/load register writes in a FIFO, drains one per cycle
// to the register file write port, and forwards the newest pending data to readers.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aluValid,
    input  logic [4:0]               aluReg,
    input  logic [31:0]              aluData,
    output logic                     aluReady,
    input  logic                     memValid,
    input  logic [4:0]               memReg,
    input  logic [31:0]              memData,
    output logic                     memReady,
    input  logic                     wbStall,
    output logic                     WB,
    output logic [4:0]               writeReg,
    output logic [31:0]              writeData,
    input  logic [4:0]               readReg1,
    input  logic [4:0]               readReg2,
    output logic                     fwdHit1,
    output logic                     fwdHit2,
    output logic [31:0]              fwdData1,
    output logic [31:0]              fwdData2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    fifo_reg  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] head, tail;
    logic          push_mem, push, pop;
    logic [4:0]    acc_reg;
    logic [31:0]   acc_data;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign memReady = !full;
    assign aluReady = !full && !memValid;
    assign push_mem = memValid && memReady;
    assign acc_reg  = push_mem ? memReg : aluReg;
    assign acc_data = push_mem ? memData : aluData;
    // Writes to r0 are acknowledged but never stored
    assign push     = (push_mem || (aluValid && aluReady)) && acc_reg != 5'd0;
    assign pop      = !wbStall && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            WB        <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            WB <= pop;
            if (pop) begin
                writeReg  <= fifo_reg[head];
                writeData <= fifo_data[head];
                head      <= head + 1'b1;
            end
            if (push) begin
                fifo_reg[tail]  <= acc_reg;
                fifo_data[tail] <= acc_data;
                tail            <= tail + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Scan oldest to newest so later matches override: output stage < older < newer
    always_comb begin
        fwdHit1  = WB && writeReg == readReg1 && readReg1 != 5'd0;
        fwdHit2  = WB && writeReg == readReg2 && readReg2 != 5'd0;
        fwdData1 = fwdHit1 ? writeData : '0;
        fwdData2 = fwdHit2 ? writeData : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count && fifo_reg[head + AW'(i)] == readReg1 && readReg1 != 5'd0) begin
                fwdHit1  = 1'b1;
                fwdData1 = fifo_data[head + AW'(i)];
            end
            if ((AW+1)'(i) < count && fifo_reg[head + AW'(i)] == readReg2 && readReg2 != 5'd0) begin
                fwdHit2  = 1'b1;
                fwdData2 = fifo_data[head + AW'(i)];
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed test plan plus random traffic, checked every cycle
// against a queue-based reference model of the write-back buffer.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk, rst;
    logic        aluValid, memValid, wbStall;
    logic [4:0]  aluReg, memReg, readReg1, readReg2;
    logic [31:0] aluData, memData;
    logic        aluReady, memReady, WB, fwdHit1, fwdHit2, full, empty;
    logic [4:0]  writeReg;
    logic [31:0] writeData, fwdData1, fwdData2;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    ent_t        q[$];
    logic        ob_v;
    logic [4:0]  ob_r;
    logic [31:0] ob_d;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
        .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
        .wbStall(wbStall), .WB(WB), .writeReg(writeReg), .writeData(writeData),
        .readReg1(readReg1), .readReg2(readReg2),
        .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic search(input logic [4:0] r, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 5'd0) begin
            for (int i = q.size() - 1; i >= 0 && !hit; i--)
                if (q[i].r == r) begin
                    hit = 1'b1;
                    d   = q[i].d;
                end
            if (!hit && ob_v && ob_r == r) begin
                hit = 1'b1;
                d   = ob_d;
            end
        end
    endtask

    task automatic model_check();
        logic        h;
        logic [31:0] d;
        int          sz;
        sz = q.size();
        chk("count", count, sz);
        chk("full", full, sz == DEPTH);
        chk("empty", empty, sz == 0);
        chk("memReady", memReady, sz != DEPTH);
        chk("aluReady", aluReady, sz != DEPTH && !memValid);
        chk("WB", WB, ob_v);
        chk("writeReg", writeReg, ob_r);
        chk("writeData", writeData, ob_d);
        search(readReg1, h, d);
        chk("fwdHit1", fwdHit1, h);
        chk("fwdData1", fwdData1, d);
        search(readReg2, h, d);
        chk("fwdHit2", fwdHit2, h);
        chk("fwdData2", fwdData2, d);
    endtask

    task automatic model_update();
        logic       acc_v, full_m;
        ent_t       e, a;
        if (rst) begin
            q.delete();
            ob_v = 1'b0;
            ob_r = '0;
            ob_d = '0;
        end else begin
            full_m = q.size() == DEPTH;
            acc_v  = 1'b0;
            a      = '0;
            if (memValid && !full_m) begin
                acc_v = 1'b1;
                a     = '{memReg, memData};
            end else if (aluValid && !full_m) begin
                acc_v = 1'b1;
                a     = '{aluReg, aluData};
            end
            if (!wbStall && q.size() != 0) begin
                e    = q.pop_front();
                ob_v = 1'b1;
                ob_r = e.r;
                ob_d = e.d;
            end else
                ob_v = 1'b0;
            if (acc_v && a.r != 5'd0) q.push_back(a);
        end
    endtask

    task automatic set_in(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                          input logic av, input logic [4:0] ar, input logic [31:0] ad,
                          input logic st, input logic [4:0] r1, input logic [4:0] r2,
                          input logic rs);
        memValid = mv; memReg = mr; memData = md;
        aluValid = av; aluReg = ar; aluData = ad;
        wbStall  = st; readReg1 = r1; readReg2 = r2; rst = rs;
    endtask

    task automatic tick();
        #1 model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic st, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0, st, r1, r2, 0);
            tick();
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        model_update();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_WB", WB, 0);

        // single write r20=50
        set_in(0, 0, 0, 1, 20, 50, 0, 0, 20, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 20, 0);
        #1 chk("single_count", count, 1);
        chk("single_fwdHit2", fwdHit2, 1);
        chk("single_fwdData2", fwdData2, 50);
        tick();
        #1 chk("single_WB", WB, 1);
        chk("single_writeReg", writeReg, 20);
        chk("single_writeData", writeData, 50);
        tick();
        #1 chk("single_WB_off", WB, 0);
        chk("single_count0", count, 0);
        idle(1, 0, 0, 0);

        // simultaneous mem r3=7 and alu r4=9
        set_in(1, 3, 7, 1, 4, 9, 0, 3, 4, 0);
        #1 chk("arb_memReady", memReady, 1);
        chk("arb_aluReady", aluReady, 0);
        tick();
        set_in(0, 0, 0, 1, 4, 9, 0, 3, 4, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 3, 4, 0);
        #1 chk("arb_first_reg", writeReg, 3);
        chk("arb_first_data", writeData, 7);
        tick();
        #1 chk("arb_second_reg", writeReg, 4);
        chk("arb_second_data", writeData, 9);
        idle(2, 0, 3, 4);

        // full and wrap
        for (int i = 1; i <= 4; i++) begin
            set_in(0, 0, 0, 1, 5'(i), 32'(10 + i), 1, 5'(i), 5, 0);
            tick();
        end
        set_in(0, 0, 0, 1, 5, 15, 1, 1, 5, 0);
        #1 chk("wrap_full", full, 1);
        chk("wrap_aluReady", aluReady, 0);
        tick();
        set_in(0, 0, 0, 1, 5, 15, 0, 1, 5, 0);
        tick();
        set_in(0, 0, 0, 1, 5, 15, 0, 1, 5, 0);
        tick();
        idle(6, 0, 2, 5);

        // r0 is acknowledged and dropped
        set_in(0, 0, 0, 1, 0, 99, 0, 0, 0, 0);
        #1 chk("r0_aluReady", aluReady, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("r0_count", count, 0);
        chk("r0_fwdHit1", fwdHit1, 0);
        idle(2, 0, 0, 0);

        // newest wins
        set_in(0, 0, 0, 1, 5, 1, 1, 5, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 5, 2, 1, 5, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        #1 chk("newest_fifo", fwdData1, 2);
        tick();
        idle(2, 0, 5, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        #1 chk("newest_out_WB", WB, 1);
        chk("newest_out_data", writeData, 2);
        chk("newest_out_fwd", fwdData1, 2);
        idle(2, 0, 5, 0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 1, 5'(6 + i), 32'(100 + i), 1, 6, 8, 0);
            tick();
        end
        set_in(0, 0, 0, 1, 9, 200, 1, 6, 8, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 1, 6, 8, 0);
        #1 chk("rst_count", count, 0);
        chk("rst_WB", WB, 0);
        chk("rst_fwdHit1", fwdHit1, 0);
        chk("rst_fwdHit2", fwdHit2, 0);
        idle(4, 0, 6, 8);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            set_in($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 99) < 2);
            tick();
        end
        idle(6, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
